rf_access_arbiter: RTL and testbench

- Sequences and shares the PE register file (register_system) between two requesters: port 0 is the PE core pipeline and port 1 is the CGRA interconnect/config loader.
- Each requester issues either a write or a one/two-operand read over a valid/ready handshake.
- The arbiter grants round-robin, drives the register-file control and select lines, and returns read data over a valid/ready response channel.
- Enforces RISC-V x0 semantics in front of the register file.

---
 rtl/rf_access_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_rf_access_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_access_arbiter.sv
// rf_access_arbiter
//   Shares the PE register file between two requesters (0 = PE core pipeline,
//   1 = CGRA interconnect / config loader). Requests are granted round-robin,
//   issued to the register file one at a time, and read results are returned
//   on a per-requester valid/ready response channel. RISC-V x0 semantics are
//   applied in front of the register file unless ZERO_REG_WRITABLE is set.
//
// Parameters
//   RD_LAT            register-file read latency, read_en to data_out (0..3)
//   ZERO_REG_WRITABLE 0: register 0 reads as zero, writes to it are dropped
//
// Ports
//   clk, reset                   clock, async active-low reset
//   req_valid/ready/write/two    per-requester request handshake and type
//   req_rd/rs1/rs2, req_wdata    packed per-requester request fields
//   rsp_valid/ready              per-requester read response handshake
//   rsp_data1/2                  shared response data, qualified by rsp_valid
//   selRD/selRS1/selRS2          register-file selects
//   reg_select, data_in          dual-output enable, write data
//   rdwrite, read_en             register-file write / read enables
//   data_out1/2                  register-file read data
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | arbitrate; req_ready to the winner; latch request on acceptance
// ISSUE | write: one-cycle rdwrite; read: first read_en cycle
// WAIT  | read latency wait; data captured at the end of the last WAIT
// RESP  | hold rsp_valid to the owner until its rsp_ready
module rf_access_arbiter #(
    parameter int unsigned RD_LAT            = 1,
    parameter bit          ZERO_REG_WRITABLE = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_write,
    input  logic [1:0]  req_two,
    input  logic [9:0]  req_rd,
    input  logic [9:0]  req_rs1,
    input  logic [9:0]  req_rs2,
    input  logic [63:0] req_wdata,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_data1,
    output logic [31:0] rsp_data2,
    output logic [4:0]  selRD,
    output logic [4:0]  selRS1,
    output logic [4:0]  selRS2,
    output logic        reg_select,
    output logic [31:0] data_in,
    output logic        rdwrite,
    output logic        read_en,
    input  logic [31:0] data_out1,
    input  logic [31:0] data_out2
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // WAIT counts down from RD_LAT-1; capture happens when it reaches zero.
    localparam logic [1:0] WAIT_LOAD = (RD_LAT == 0) ? 2'd0 : 2'(RD_LAT - 1);

    state_t      state, state_nxt;
    logic        last_grant;
    logic        owner;
    logic        op_write;
    logic        op_two;
    logic [4:0]  op_rd;
    logic [4:0]  op_rs1;
    logic [4:0]  op_rs2;
    logic [31:0] op_wdata;
    logic [1:0]  wait_cnt;
    logic [31:0] cap_d1;
    logic [31:0] cap_d2;

    logic        win;
    logic        accept;
    logic        capture;
    logic        rs1_zero;
    logic        rs2_zero;

    always_comb begin
        win = 1'b0;
        if (req_valid == 2'b11) begin
            win = ~last_grant;
        end else if (req_valid == 2'b10) begin
            win = 1'b1;
        end
    end

    // reset is folded in so req_ready stays low while reset is held.
    assign accept   = (state == IDLE) && (|req_valid) && reset;
    assign rs1_zero = !ZERO_REG_WRITABLE && (op_rs1 == 5'd0);
    assign rs2_zero = !ZERO_REG_WRITABLE && (op_rs2 == 5'd0);

    always_comb begin
        state_nxt  = state;
        req_ready  = 2'b00;
        rsp_valid  = 2'b00;
        rsp_data1  = 32'd0;
        rsp_data2  = 32'd0;
        selRD      = 5'd0;
        selRS1     = 5'd0;
        selRS2     = 5'd0;
        reg_select = 1'b0;
        data_in    = 32'd0;
        rdwrite    = 1'b0;
        read_en    = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    req_ready[win] = 1'b1;
                    state_nxt      = ISSUE;
                end
            end
            ISSUE: begin
                if (op_write) begin
                    selRD     = op_rd;
                    data_in   = op_wdata;
                    rdwrite   = ZERO_REG_WRITABLE || (op_rd != 5'd0);
                    state_nxt = IDLE;
                end else begin
                    selRS1     = op_rs1;
                    selRS2     = op_rs2;
                    reg_select = op_two;
                    read_en    = 1'b1;
                    if (RD_LAT == 0) begin
                        capture   = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                selRS1     = op_rs1;
                selRS2     = op_rs2;
                reg_select = op_two;
                read_en    = 1'b1;
                if (wait_cnt == 2'd0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid[owner] = 1'b1;
                rsp_data1        = cap_d1;
                rsp_data2        = cap_d2;
                if (rsp_ready[owner]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_write   <= 1'b0;
            op_two     <= 1'b0;
            op_rd      <= 5'd0;
            op_rs1     <= 5'd0;
            op_rs2     <= 5'd0;
            op_wdata   <= 32'd0;
            wait_cnt   <= 2'd0;
            cap_d1     <= 32'd0;
            cap_d2     <= 32'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner      <= win;
                last_grant <= win;
                op_write   <= req_write[win];
                op_two     <= req_two[win];
                op_rd      <= win ? req_rd[9:5]      : req_rd[4:0];
                op_rs1     <= win ? req_rs1[9:5]     : req_rs1[4:0];
                op_rs2     <= win ? req_rs2[9:5]     : req_rs2[4:0];
                op_wdata   <= win ? req_wdata[63:32] : req_wdata[31:0];
            end
            if (state == ISSUE) begin
                wait_cnt <= WAIT_LOAD;
            end else if ((state == WAIT) && (wait_cnt != 2'd0)) begin
                wait_cnt <= wait_cnt - 2'd1;
            end
            if (capture) begin
                cap_d1 <= rs1_zero ? 32'd0 : data_out1;
                cap_d2 <= (!op_two || rs2_zero) ? 32'd0 : data_out2;
            end
        end
    end

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Testbench for rf_access_arbiter: three instances (RD_LAT 1, 0, 3), each with
// a behavioural register file behind it. Register 0 of the model holds junk so
// the arbiter's zero-forcing is visible; data_out2 is junk when reg_select=0.
module tb_rf_access_arbiter;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid [N];
    logic [1:0]  req_ready [N];
    logic [1:0]  req_write [N];
    logic [1:0]  req_two   [N];
    logic [9:0]  req_rd    [N];
    logic [9:0]  req_rs1   [N];
    logic [9:0]  req_rs2   [N];
    logic [63:0] req_wdata [N];
    logic [1:0]  rsp_valid [N];
    logic [1:0]  rsp_ready [N];
    logic [31:0] rsp_data1 [N];
    logic [31:0] rsp_data2 [N];
    logic [4:0]  selRD     [N];
    logic [4:0]  selRS1    [N];
    logic [4:0]  selRS2    [N];
    logic        reg_select[N];
    logic [31:0] data_in   [N];
    logic        rdwrite   [N];
    logic        read_en   [N];
    logic [31:0] data_out1 [N];
    logic [31:0] data_out2 [N];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int i);
        return (i == 1) ? 0 : (i == 2) ? 3 : 1;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int L = (g == 1) ? 0 : (g == 2) ? 3 : 1;

        rf_access_arbiter #(.RD_LAT(L), .ZERO_REG_WRITABLE(1'b0)) u_dut (
            .clk(clk), .reset(reset),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .req_write(req_write[g]), .req_two(req_two[g]),
            .req_rd(req_rd[g]), .req_rs1(req_rs1[g]), .req_rs2(req_rs2[g]),
            .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
            .rsp_data1(rsp_data1[g]), .rsp_data2(rsp_data2[g]),
            .selRD(selRD[g]), .selRS1(selRS1[g]), .selRS2(selRS2[g]),
            .reg_select(reg_select[g]), .data_in(data_in[g]),
            .rdwrite(rdwrite[g]), .read_en(read_en[g]),
            .data_out1(data_out1[g]), .data_out2(data_out2[g])
        );

        logic [31:0] mem [32];
        logic [31:0] p1 [4];
        logic [31:0] p2 [4];
        logic [31:0] m1, m2;

        assign m1 = (selRS1[g] == 5'd0) ? 32'hBAD0_0001 : mem[selRS1[g]];
        assign m2 = (selRS2[g] == 5'd0) ? 32'hBAD0_0002 : mem[selRS2[g]];

        always @(posedge clk) begin
            if (rdwrite[g]) mem[selRD[g]] <= data_in[g];
            p1[0] <= m1;
            p2[0] <= m2;
            for (int k = 1; k < 4; k++) begin
                p1[k] <= p1[k-1];
                p2[k] <= p2[k-1];
            end
        end

        if (L == 0) begin : g_l0
            assign data_out1[g] = m1;
            assign data_out2[g] = reg_select[g] ? m2 : 32'hDEAD_BEEF;
        end else begin : g_ln
            assign data_out1[g] = p1[L-1];
            assign data_out2[g] = reg_select[g] ? p2[L-1] : 32'hDEAD_BEEF;
        end
    end

    // Bus monitor: counts register-file enables and responses per instance.
    int          wr_cnt [N];
    int          ren_cnt[N];
    int          rv_cnt [N];
    logic [4:0]  last_selrd[N];
    logic [31:0] last_din  [N];
    logic        last_rsel [N];

    initial begin
        for (int i = 0; i < N; i++) begin
            wr_cnt[i] = 0; ren_cnt[i] = 0; rv_cnt[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rdwrite[i]) begin
                wr_cnt[i]     <= wr_cnt[i] + 1;
                last_selrd[i] <= selRD[i];
                last_din[i]   <= data_in[i];
            end
            if (read_en[i]) begin
                ren_cnt[i]   <= ren_cnt[i] + 1;
                last_rsel[i] <= reg_select[i];
            end
            if (|rsp_valid[i]) rv_cnt[i] <= rv_cnt[i] + 1;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        int          inst;
        int          port;
        bit          wr;
        bit          two;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] wdata;
        logic [31:0] exp_d1;
        logic [31:0] exp_d2;
        int          exp_pulses;
    } vec_t;

    function automatic vec_t mk(input int inst, input int port, input bit wr, input bit two,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] wdata, input logic [31:0] d1,
                                input logic [31:0] d2, input int pulses);
        vec_t v;
        v.inst = inst; v.port = port; v.wr = wr; v.two = two;
        v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.wdata = wdata;
        v.exp_d1 = d1; v.exp_d2 = d2; v.exp_pulses = pulses;
        return v;
    endfunction

    task automatic set_req(input int i, input int p, input bit wr, input bit two,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] wdata);
        req_write[i][p]          = wr;
        req_two[i][p]            = two;
        req_rd[i][5*p +: 5]      = rd;
        req_rs1[i][5*p +: 5]     = rs1;
        req_rs2[i][5*p +: 5]     = rs2;
        req_wdata[i][32*p +: 32] = wdata;
        req_valid[i][p]          = 1'b1;
    endtask

    task automatic do_txn(input vec_t v, input string tag);
        int i, p, acc, w0, r0, v0;
        bit got;
        i = v.inst;
        p = v.port;
        set_req(i, p, v.wr, v.two, v.rd, v.rs1, v.rs2, v.wdata);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready[i][p]) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, " accept"}, 32'(got), 32'd1);
        if (!got) begin
            req_valid[i][p] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        acc = cyc; w0 = wr_cnt[i]; r0 = ren_cnt[i]; v0 = rv_cnt[i];
        req_valid[i][p] = 1'b0;
        if (v.wr) begin
            repeat (3) @(posedge clk);
            #1;
            chk({tag, " rdwrite pulses"}, 32'(wr_cnt[i] - w0), 32'(v.exp_pulses));
            if (v.exp_pulses != 0) begin
                chk({tag, " selRD"}, 32'(last_selrd[i]), 32'(v.rd));
                chk({tag, " data_in"}, last_din[i], v.wdata);
            end
            chk({tag, " no rsp"}, 32'(rv_cnt[i] - v0), 32'd0);
        end else begin
            got = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (rsp_valid[i][p]) begin
                    got = 1'b1;
                    break;
                end
            end
            chk({tag, " rsp seen"}, 32'(got), 32'd1);
            chk({tag, " latency"}, 32'(cyc - acc), 32'(1 + lat_of(i)));
            chk({tag, " rsp_valid"}, 32'(rsp_valid[i]), (p == 0) ? 32'd1 : 32'd2);
            chk({tag, " rsp_data1"}, rsp_data1[i], v.exp_d1);
            chk({tag, " rsp_data2"}, rsp_data2[i], v.exp_d2);
            rsp_ready[i][p] = 1'b1;
            @(posedge clk); #1;
            rsp_ready[i][p] = 1'b0;
            chk({tag, " rsp dropped"}, 32'(rsp_valid[i]), 32'd0);
            chk({tag, " read_en cycles"}, 32'(ren_cnt[i] - r0), 32'(1 + lat_of(i)));
            chk({tag, " reg_select"}, 32'(last_rsel[i]), 32'(v.two));
            chk({tag, " no rdwrite"}, 32'(wr_cnt[i] - w0), 32'd0);
        end
    endtask

    vec_t vecs [11];

    initial begin : main
        logic [31:0] hold1, hold2;
        int v0, ngr, exp_g, pend, last_gcyc, g;
        bit got;

        vecs[0]  = mk(0, 0, 1, 0, 14,  0,  0, 32'h5A5A5A5A, 0, 0, 1);
        vecs[1]  = mk(0, 0, 0, 0,  0, 14,  3, 0, 32'h5A5A5A5A, 32'h0, 0);
        vecs[2]  = mk(0, 1, 1, 0,  0,  0,  0, 32'hA5A5A5A5, 0, 0, 0);
        vecs[3]  = mk(0, 1, 0, 1,  0,  0, 14, 0, 32'h0, 32'h5A5A5A5A, 0);
        vecs[4]  = mk(0, 0, 0, 1,  0, 14,  0, 0, 32'h5A5A5A5A, 32'h0, 0);
        vecs[5]  = mk(0, 1, 1, 0,  9,  0,  0, 32'hC0FFEE09, 0, 0, 1);
        vecs[6]  = mk(0, 1, 0, 1,  0,  9, 14, 0, 32'hC0FFEE09, 32'h5A5A5A5A, 0);
        vecs[7]  = mk(1, 0, 1, 0, 14,  0,  0, 32'h5A5A5A5A, 0, 0, 1);
        vecs[8]  = mk(1, 0, 0, 0,  0, 14,  3, 0, 32'h5A5A5A5A, 32'h0, 0);
        vecs[9]  = mk(2, 0, 1, 0, 14,  0,  0, 32'h5A5A5A5A, 0, 0, 1);
        vecs[10] = mk(2, 0, 0, 0,  0, 14,  3, 0, 32'h5A5A5A5A, 32'h0, 0);

        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = '0; req_write[i] = '0; req_two[i] = '0;
            req_rd[i] = '0; req_rs1[i] = '0; req_rs2[i] = '0;
            req_wdata[i] = '0; rsp_ready[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset req_ready", 32'(req_ready[0]), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("reset rf enables", {30'd0, rdwrite[0], read_en[0]}, 32'd0);
        chk("reset rsp_data1", rsp_data1[0], 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int n = 0; n < 11; n++) begin
            do_txn(vecs[n], $sformatf("vec%0d", n));
        end

        // Reset while a port-0 read sits in WAIT.
        set_req(0, 0, 1'b0, 1'b0, 5'd0, 5'd14, 5'd0, 32'd0);
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready[0][0]) begin
                got = 1'b1;
                break;
            end
        end
        chk("abort accept", 32'(got), 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 2'b00;
        @(posedge clk); #1;
        chk("abort read_en in WAIT", 32'(read_en[0]), 32'd1);
        v0 = rv_cnt[0];
        reset = 1'b0;
        #1;
        chk("abort outputs zero", {20'd0, req_ready[0], rsp_valid[0], rdwrite[0], read_en[0],
                                  reg_select[0], selRS1[0] != 5'd0, selRD[0] != 5'd0,
                                  data_in[0] != 32'd0}, 32'd0);
        chk("abort rsp_data1 zero", rsp_data1[0], 32'd0);
        set_req(0, 0, 1'b1, 1'b0, 5'd31, 5'd0, 5'd0, 32'h12345678);
        set_req(0, 1, 1'b1, 1'b0, 5'd12, 5'd0, 5'd0, 32'h87654321);
        @(negedge clk);
        chk("req_ready held in reset", 32'(req_ready[0]), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Both requesters write continuously: strict alternation from port 0.
        exp_g = 0; ngr = 0; pend = -1; last_gcyc = 0;
        for (int k = 0; k < 40 && ngr < 8; k++) begin
            @(negedge clk);
            if (rdwrite[0]) begin
                chk("alt selRD", 32'(selRD[0]), (pend == 1) ? 32'd12 : 32'd31);
                chk("alt data_in", data_in[0], (pend == 1) ? 32'h87654321 : 32'h12345678);
            end
            if (|req_ready[0]) begin
                g = req_ready[0][1] ? 1 : 0;
                chk("alt grant", 32'(req_ready[0]), (exp_g == 0) ? 32'd1 : 32'd2);
                if (ngr > 0) chk("alt spacing", 32'(cyc - last_gcyc), 32'd2);
                last_gcyc = cyc;
                pend = g;
                exp_g = 1 - exp_g;
                ngr++;
            end
        end
        chk("alt grant count", 32'(ngr), 32'd8);
        req_valid[0] = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("no rsp after abort", 32'(rv_cnt[0] - v0), 32'd0);

        // Response backpressure with the other requester pending.
        set_req(0, 1, 1'b0, 1'b1, 5'd0, 5'd14, 5'd31, 32'd0);
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready[0][1]) begin
                got = 1'b1;
                break;
            end
        end
        chk("bp accept", 32'(got), 32'd1);
        @(posedge clk); #1;
        req_valid[0][1] = 1'b0;
        set_req(0, 0, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 32'h00000055);
        rsp_ready[0][0] = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid[0][1]) begin
                got = 1'b1;
                break;
            end
        end
        chk("bp rsp seen", 32'(got), 32'd1);
        hold1 = rsp_data1[0];
        hold2 = rsp_data2[0];
        chk("bp rsp_data1", hold1, 32'h5A5A5A5A);
        chk("bp rsp_data2", hold2, 32'h12345678);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("bp rsp_valid held", 32'(rsp_valid[0]), 32'd2);
            chk("bp data1 stable", rsp_data1[0], hold1);
            chk("bp data2 stable", rsp_data2[0], hold2);
            chk("bp req_ready low", 32'(req_ready[0]), 32'd0);
        end
        rsp_ready[0] = 2'b10;
        @(posedge clk); #1;
        rsp_ready[0] = 2'b00;
        @(negedge clk);
        chk("bp next grant", 32'(req_ready[0]), 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("bp write selRD", 32'(last_selrd[0]), 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
